// File: rtl/alarm_controller.sv
// Alarm clock keypad/button sequencer: Moore FSM steering display select and load strobes.
// Define ALARM_CONTROLLER_TIMEOUT_EN to abandon keypad entry after TIMEOUT_SECS idle seconds.
module alarm_controller #(
    parameter int unsigned TIMEOUT_SECS = 10,
    parameter logic [3:0]  NOKEY        = 4'd10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       show_new_time,
    output logic       show_alarm,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c
);

    typedef enum logic [2:0] {
        SHOW_TIME,
        KEY_STORED,
        KEY_WAITED,
        KEY_ENTRY,
        SHOW_ALARM,
        SET_ALARM_TIME,
        SET_CURRENT_TIME
    } state_t;

    state_t state_q, state_d;
    logic   key_pressed;
    logic   timeout;

    assign key_pressed = (key != NOKEY);

`ifdef ALARM_CONTROLLER_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_SECS - 1);

    logic [3:0] cnt_q, cnt_d;
    logic       counting;

    assign counting = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
    assign timeout  = one_second && (cnt_q == TIMEOUT_LAST);

    // Count restarts with every digit; it only runs while waiting on the keypad.
    always_comb begin
        cnt_d = cnt_q;
        if (!counting || state_d == KEY_STORED) begin
            cnt_d = 4'd0;
        end else if (one_second && cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_one_second;

    assign unused_one_second = one_second;
    assign timeout           = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SHOW_TIME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SHOW_TIME: begin
                if (alarm_button) begin
                    state_d = SHOW_ALARM;
                end else if (key_pressed) begin
                    state_d = KEY_STORED;
                end
            end
            KEY_STORED: state_d = KEY_WAITED;
            // A held key must be released before the next digit can be taken.
            KEY_WAITED: begin
                if (!key_pressed) begin
                    state_d = KEY_ENTRY;
                end else if (timeout) begin
                    state_d = SHOW_TIME;
                end
            end
            KEY_ENTRY: begin
                if (alarm_button) begin
                    state_d = SET_ALARM_TIME;
                end else if (time_button) begin
                    state_d = SET_CURRENT_TIME;
                end else if (key_pressed) begin
                    state_d = KEY_STORED;
                end else if (timeout) begin
                    state_d = SHOW_TIME;
                end
            end
            SHOW_ALARM: begin
                if (!alarm_button) begin
                    state_d = SHOW_TIME;
                end
            end
            SET_ALARM_TIME:   state_d = SHOW_TIME;
            SET_CURRENT_TIME: state_d = SHOW_TIME;
            default:          state_d = SHOW_TIME;
        endcase
    end

    always_comb begin
        show_new_time = (state_q == KEY_STORED) || (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
        show_alarm    = (state_q == SHOW_ALARM);
        shift         = (state_q == KEY_STORED);
        load_new_a    = (state_q == SET_ALARM_TIME);
        load_new_c    = (state_q == SET_CURRENT_TIME);
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Randomised and directed bench for alarm_controller against a rule-level reference model.
module tb_alarm_controller;

    localparam int         TSECS = 10;
    localparam logic [3:0] NK    = 4'd10;
`ifdef ALARM_CONTROLLER_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       one_second = 1'b0;
    logic [3:0] key = NK;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic       show_new_time, show_alarm, shift, load_new_a, load_new_c;

    alarm_controller #(.TIMEOUT_SECS(TSECS), .NOKEY(NK)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .one_second   (one_second),
        .key          (key),
        .alarm_button (alarm_button),
        .time_button  (time_button),
        .show_new_time(show_new_time),
        .show_alarm   (show_alarm),
        .shift        (shift),
        .load_new_a   (load_new_a),
        .load_new_c   (load_new_c)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: user-visible situation rather than FSM encoding.
    bit m_entry;  // keypad entry sequence in progress
    bit m_shift;  // digit just captured this cycle
    bit m_held;   // captured digit not yet released
    bit m_view;   // alarm time being shown
    int m_load;   // 0 none, 1 alarm load, 2 clock load
    int m_secs;   // one_second pulses since last digit

    task automatic model_reset();
        m_entry = 0; m_shift = 0; m_held = 0; m_view = 0; m_load = 0; m_secs = 0;
    endtask

    function automatic logic [4:0] model_out();
        return {m_entry, m_view, m_shift, m_load == 1, m_load == 2};
    endfunction

    task automatic model_step();
        bit dig;
        bit tmo;
        dig = (key != NK);
        tmo = TEN && one_second && (m_secs == TSECS - 1);
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (m_load != 0) begin
            m_load = 0;
        end else if (m_view) begin
            m_view = alarm_button;
        end else if (!m_entry) begin
            if (alarm_button) m_view = 1;
            else if (dig) begin m_entry = 1; m_shift = 1; m_held = 1; m_secs = 0; end
        end else if (m_shift) begin
            m_shift = 0;
        end else begin
            if (m_held) begin
                if (!dig) m_held = 0;
                else if (tmo) begin m_entry = 0; m_held = 0; end
            end else begin
                if (alarm_button) begin m_entry = 0; m_load = 1; end
                else if (time_button) begin m_entry = 0; m_load = 2; end
                else if (dig) begin m_shift = 1; m_held = 1; m_secs = 0; end
                else if (tmo) m_entry = 0;
            end
            if (!m_shift && one_second && m_secs < 15) m_secs++;
        end
    endtask

    logic [4:0] dut_out;
    assign dut_out = {show_new_time, show_alarm, shift, load_new_a, load_new_c};

    int n_shift, n_la, n_lc;

    task automatic cyc(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check(tag, dut_out, model_out());
        if (shift) n_shift++;
        if (load_new_a) n_la++;
        if (load_new_c) n_lc++;
        if (show_alarm && show_new_time) check("excl_display", 1, 0);
        if (int'(shift) + int'(load_new_a) + int'(load_new_c) > 1) check("excl_strobe", 1, 0);
        one_second = 1'b0;
    endtask

    task automatic clr_counts();
        n_shift = 0; n_la = 0; n_lc = 0;
    endtask

    task automatic press(input logic [3:0] d);
        key = d; cyc("press");
        key = NK; cyc("release"); cyc("release2");
    endtask

    initial begin
        model_reset();
        clr_counts();
        #2;
        check("reset_async", dut_out, 5'b0);
        repeat (3) cyc("in_reset");
        reset_n = 1'b1;
        repeat (20) cyc("idle");
        check("idle_outputs", dut_out, 5'b0);

        // Held digit yields one shift.
        clr_counts();
        key = 4'd5;
        repeat (6) cyc("hold5");
        key = NK;
        repeat (3) cyc("rel5");
        check("hold5_shifts", n_shift, 1);
        check("hold5_display", show_new_time, 1);
        time_button = 1'b1; cyc("tb_a"); time_button = 1'b0;
        repeat (2) cyc("tb_b");

        // Two digits then a clock load.
        clr_counts();
        press(4'd1);
        press(4'd2);
        time_button = 1'b1; cyc("time_btn"); time_button = 1'b0;
        cyc("after_time");
        check("set_time_shifts", n_shift, 2);
        check("set_time_loadc", n_lc, 1);
        check("set_time_display", show_new_time, 0);
        cyc("settle");

        // Idle-second handling in entry.
        clr_counts();
        press(4'd7);
        repeat (TSECS) begin one_second = 1'b1; cyc("sec"); cyc("gap"); end
        check("tmo_display", show_new_time, TEN ? 1'b0 : 1'b1);
        check("tmo_no_load", n_la + n_lc, 0);
        if (!TEN) begin time_button = 1'b1; cyc("exit"); time_button = 1'b0; cyc("exit2"); end
        press(4'd7);
        repeat (TSECS - 1) begin one_second = 1'b1; cyc("sec9"); end
        press(4'd8);
        repeat (TSECS - 1) begin one_second = 1'b1; cyc("sec9b"); end
        check("no_tmo_after_digit", show_new_time, 1);

        // Both buttons in entry: alarm load only.
        clr_counts();
        alarm_button = 1'b1; time_button = 1'b1; cyc("both");
        alarm_button = 1'b0; time_button = 1'b0; cyc("both2");
        check("both_loada", n_la, 1);
        check("both_loadc", n_lc, 0);
        cyc("settle2");

        // Alarm view ignores digits.
        alarm_button = 1'b1; key = 4'd3;
        repeat (5) cyc("alarm_hold");
        check("alarm_view", show_alarm, 1);
        alarm_button = 1'b0; key = NK;
        cyc("alarm_rel");
        check("alarm_view_off", dut_out, 5'b0);
        cyc("settle3");

        // Asynchronous reset mid-entry.
        key = 4'd4; cyc("k4"); cyc("k4w");
        #2 reset_n = 1'b0;
        #1 model_reset();
        check("reset_mid_entry", dut_out, 5'b0);
        cyc("held_reset");
        reset_n = 1'b1; key = NK;
        clr_counts();
        repeat (4) cyc("post_reset");
        check("post_reset_strobes", n_shift + n_la + n_lc, 0);

        // Long idle stretch in entry.
        press(4'd9);
        repeat (20) begin one_second = 1'b1; cyc("sec20"); cyc("gap20"); end
        check("long_idle_display", show_new_time, TEN ? 1'b0 : 1'b1);
        time_button = 1'b1; cyc("out"); time_button = 1'b0; cyc("out2");

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0)
                key = ($urandom_range(0, 1) == 0) ? NK : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) alarm_button = ~alarm_button;
            time_button = ($urandom_range(0, 11) == 0);
            one_second  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 400) == 0) begin
                #2 reset_n = 1'b0;
                #1 model_reset();
                check("rand_async_reset", dut_out, 5'b0);
                cyc("rand_in_reset");
                reset_n = 1'b1;
            end else begin
                cyc("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter TIMEOUT_SECS, default 10, one_second pulses of keypad inactivity before entry is abandoned (legal range 1..15).
REQ-002 Parameter NOKEY, default 4'd10, key code meaning "no key pressed".
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 one_second  input  1  one-clock-wide pulse, once per second.
REQ-006 key  input  4  keypad code: 0..9 digit, NOKEY idle; other values treated as digits.
REQ-007 alarm_button  input  1  level, high while the alarm button is held.
REQ-008 time_button  input  1  level, high while the time button is held.
REQ-009 show_new_time  output  1  selects keypad digits for display.
REQ-010 show_alarm  output  1  selects alarm time for display.
REQ-011 shift  output  1  one-cycle strobe; key register shifts in the current digit.
REQ-012 load_new_a  output  1  one-cycle strobe; alarm register loads the key register.
REQ-013 load_new_c  output  1  one-cycle strobe; current-time counter loads the key register.

Function
REQ-014 Moore FSM, 7 states: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME; outputs decoded from registered state only.
REQ-015 SHOW_TIME: alarm_button -> SHOW_ALARM; else key != NOKEY -> KEY_STORED; else stay.
REQ-016 KEY_STORED: shift = 1; unconditionally -> KEY_WAITED next cycle.
REQ-017 KEY_WAITED: key == NOKEY -> KEY_ENTRY; else timeout -> SHOW_TIME; else stay (held key produces exactly one shift).
REQ-018 KEY_ENTRY priority: alarm_button -> SET_ALARM_TIME; time_button -> SET_CURRENT_TIME; key != NOKEY -> KEY_STORED; timeout -> SHOW_TIME; else stay.
REQ-019 SHOW_ALARM: show_alarm = 1; alarm_button low -> SHOW_TIME; key input ignored.
REQ-020 SET_ALARM_TIME: load_new_a = 1 for exactly one cycle -> SHOW_TIME.
REQ-021 SET_CURRENT_TIME: load_new_c = 1 for exactly one cycle -> SHOW_TIME.
REQ-022 show_new_time = 1 in KEY_STORED, KEY_WAITED, KEY_ENTRY; 0 elsewhere.
REQ-023 At most one of shift, load_new_a, load_new_c high in any cycle; show_alarm and show_new_time never both high.
REQ-024 Timeout counter, 4-bit: cleared on every entry into KEY_STORED and whenever state is outside {KEY_STORED, KEY_WAITED, KEY_ENTRY}.
REQ-025 Counter increments on one_second while in KEY_WAITED or KEY_ENTRY; saturates, never wraps.
REQ-026 timeout is true when one_second is high and counter == TIMEOUT_SECS-1 (the TIMEOUT_SECS-th pulse since last digit).
REQ-027 alarm_button and time_button high together in KEY_ENTRY: alarm_button wins.
REQ-028 Digit and timeout in same cycle in KEY_ENTRY: digit wins, counter clears.
REQ-029 Entry state is reached only via KEY_STORED, so load strobes require at least one digit entered.

Reset
REQ-030 reset_n low forces state SHOW_TIME and counter 0 immediately, independent of clock.
REQ-031 During reset: show_new_time, show_alarm, shift, load_new_a, load_new_c all 0.
REQ-032 Reset asserted mid-entry or during a load strobe aborts it; no strobe is emitted after reset release until a new sequence.
REQ-033 First state change after reset_n deasserts occurs on the next rising clock edge.

Configuration
REQ-034 Macro ALARM_CONTROLLER_TIMEOUT_EN defined: timeout counter and REQ-024..026 behaviour present.
REQ-035 Macro undefined: no counter logic, timeout constant false; FSM stays in entry states until a button or digit; one_second unused.

Verification
REQ-036 Reset, key=NOKEY, buttons low, 20 cycles -> all outputs 0, state SHOW_TIME.
REQ-037 key=5 held 6 cycles then NOKEY -> shift high exactly 1 cycle; show_new_time high from cycle after key until sequence ends.
REQ-038 Digits 1,2 (each press/release) then time_button pulse -> two shift strobes, then load_new_c high 1 cycle, then show_new_time 0.
REQ-039 Digit 7 then 10 one_second pulses with no key (TIMEOUT_SECS=10) -> return to SHOW_TIME after 10th pulse, no load strobe; 9 pulses then digit -> no timeout.
REQ-040 alarm_button held 5 cycles in SHOW_TIME -> show_alarm high cycles 2..6, key=3 ignored; in KEY_ENTRY with both buttons high -> load_new_a only.
REQ-041 reset_n pulsed low in KEY_WAITED -> outputs 0 asynchronously; with ALARM_CONTROLLER_TIMEOUT_EN undefined, 20 one_second pulses in KEY_ENTRY -> no exit.
